// File: rtl/ahb_slave_interface_if.sv
// ahb_slave_interface_if: AHB-side bundle of the bridge front end.
// Inputs to the slave: hwrite, hreadyin, htrans, hsize, haddr, hwdata, prdata.
// Outputs from the slave: valid, tempselx, hwritereg, haddr1/2, hwdata1/2, hrdata, hresp, err_hreadyout, err_count.
interface ahb_slave_interface_if;
    logic        hwrite;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        valid;
    logic [2:0]  tempselx;
    logic        hwritereg;
    logic [31:0] haddr1;
    logic [31:0] haddr2;
    logic [31:0] hwdata1;
    logic [31:0] hwdata2;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic        err_hreadyout;
    logic [7:0]  err_count;
    modport slave (
        input  hwrite, hreadyin, htrans, hsize, haddr, hwdata, prdata,
        output valid, tempselx, hwritereg, haddr1, haddr2, hwdata1, hwdata2,
               hrdata, hresp, err_hreadyout, err_count
    );
    modport master (
        output hwrite, hreadyin, htrans, hsize, haddr, hwdata, prdata,
        input  valid, tempselx, hwritereg, haddr1, haddr2, hwdata1, hwdata2,
               hrdata, hresp, err_hreadyout, err_count
    );
endinterface

// File: rtl/ahb_slave_interface.sv
// ahb_slave_interface: AHB front end of the AHB-to-APB bridge (decode, pipeline, ERROR response).
// Ports: hclk (rising edge), hreset (sync active-high), bus (ahb_slave_interface_if.slave).
// Optional macro AHB_ALIGN_CHECK_EN: misaligned or oversized transfers are treated as unmapped.
module ahb_slave_interface #(
    parameter logic [31:0] SLV0_BASE   = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE   = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE   = 32'h8800_0000,
    parameter logic [31:0] REGION_SIZE = 32'h0400_0000
) (
    input logic               hclk,
    input logic               hreset,
    ahb_slave_interface_if.slave bus
);
    typedef enum logic [1:0] {ERR_IDLE, ERR_1, ERR_2} err_state_t;
    err_state_t err_state;
    logic       active;
    logic       mapped;
    logic       misaligned;
    // Offset compare keeps each range check to one unsigned subtract.
    assign bus.tempselx = (bus.haddr - SLV0_BASE) < REGION_SIZE ? 3'b001 :
                          (bus.haddr - SLV1_BASE) < REGION_SIZE ? 3'b010 :
                          (bus.haddr - SLV2_BASE) < REGION_SIZE ? 3'b100 : 3'b000;
`ifdef AHB_ALIGN_CHECK_EN
    assign misaligned = (bus.hsize == 3'b001 && bus.haddr[0]) ||
                        (bus.hsize == 3'b010 && bus.haddr[1:0] != 2'b00) ||
                        (bus.hsize >= 3'b011);
`else
    logic unused_hsize;
    assign unused_hsize = ^bus.hsize;
    assign misaligned   = 1'b0;
`endif
    assign active    = bus.hreadyin & bus.htrans[1];
    assign mapped    = (bus.tempselx != 3'b000) & ~misaligned;
    assign bus.valid = active & mapped & (err_state == ERR_IDLE);
    assign bus.hrdata = bus.prdata;
    always_ff @(posedge hclk) begin
        if (hreset) begin
            bus.haddr1        <= '0;
            bus.haddr2        <= '0;
            bus.hwdata1       <= '0;
            bus.hwdata2       <= '0;
            bus.hwritereg     <= 1'b0;
            bus.hresp         <= 2'b00;
            bus.err_hreadyout <= 1'b1;
            bus.err_count     <= '0;
            err_state         <= ERR_IDLE;
        end else begin
            if (bus.hreadyin) begin
                bus.haddr1    <= bus.haddr;
                bus.haddr2    <= bus.haddr1;
                bus.hwdata1   <= bus.hwdata;
                bus.hwdata2   <= bus.hwdata1;
                bus.hwritereg <= bus.hwrite;
            end
            // Outputs are loaded alongside the state so they track it without a decode stage.
            case (err_state)
                ERR_IDLE: begin
                    if (active & ~mapped) begin
                        err_state         <= ERR_1;
                        bus.hresp         <= 2'b01;
                        bus.err_hreadyout <= 1'b0;
                        bus.err_count     <= bus.err_count == 8'hFF ? 8'hFF : bus.err_count + 8'd1;
                    end else begin
                        bus.hresp         <= 2'b00;
                        bus.err_hreadyout <= 1'b1;
                    end
                end
                ERR_1: begin
                    err_state         <= ERR_2;
                    bus.hresp         <= 2'b01;
                    bus.err_hreadyout <= 1'b1;
                end
                default: begin
                    err_state         <= ERR_IDLE;
                    bus.hresp         <= 2'b00;
                    bus.err_hreadyout <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_slave_interface.sv
// tb_ahb_slave_interface: self-checking bench for ahb_slave_interface.
module tb_ahb_slave_interface;
    logic hclk = 1'b0;
    logic hreset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_err = 0;
    logic [31:0] aq[$];
    logic [31:0] dq[$];
    logic [1:0]  rq[$];
    logic        hq[$];
    logic [1:0]  er;
    logic        eh;
    logic [31:0] ea;
    ahb_slave_interface_if bus();
    ahb_slave_interface dut (.hclk(hclk), .hreset(hreset), .bus(bus));
    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy, input logic [2:0] sz);
        bus.htrans = tr; bus.hwrite = wr; bus.haddr = a; bus.hwdata = d;
        bus.hreadyin = rdy; bus.hsize = sz;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(2'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), 3'($urandom));
            bus.prdata = $urandom;
            tick();
        end
        n_chk++; if (bus.haddr1 !== 32'h0) begin n_fail++; $display("FAIL rst_haddr1: got %h expected %h", bus.haddr1, 32'h0); end
        n_chk++; if (bus.haddr2 !== 32'h0) begin n_fail++; $display("FAIL rst_haddr2: got %h expected %h", bus.haddr2, 32'h0); end
        n_chk++; if (bus.hwdata1 !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata1: got %h expected %h", bus.hwdata1, 32'h0); end
        n_chk++; if (bus.hwdata2 !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata2: got %h expected %h", bus.hwdata2, 32'h0); end
        n_chk++; if (bus.hwritereg !== 1'b0) begin n_fail++; $display("FAIL rst_hwritereg: got %b expected 0", bus.hwritereg); end
        n_chk++; if (bus.hresp !== 2'b00) begin n_fail++; $display("FAIL rst_hresp: got %b expected 00", bus.hresp); end
        n_chk++; if (bus.err_hreadyout !== 1'b1) begin n_fail++; $display("FAIL rst_hready: got %b expected 1", bus.err_hreadyout); end
        n_chk++; if (bus.err_count !== 8'h00) begin n_fail++; $display("FAIL rst_count: got %h expected 00", bus.err_count); end
        hreset = 1'b0;
        drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 3'b010);
        tick();
    endtask

    task automatic test_single_write();
        drive(2'b10, 1'b1, 32'h8000_0010, 32'h0, 1'b1, 3'b010);
        aq.push_back(32'h8000_0010);
        #1;
        n_chk++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL sw_valid: got %b expected 1", bus.valid); end
        n_chk++; if (bus.tempselx !== 3'b001) begin n_fail++; $display("FAIL sw_sel: got %b expected 001", bus.tempselx); end
        tick();
        n_chk++; if (bus.haddr1 !== 32'h8000_0010) begin n_fail++; $display("FAIL sw_haddr1: got %h expected 80000010", bus.haddr1); end
        n_chk++; if (bus.hwritereg !== 1'b1) begin n_fail++; $display("FAIL sw_hwritereg: got %b expected 1", bus.hwritereg); end
        drive(2'b00, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 3'b010);
        tick();
        ea = aq.pop_front();
        n_chk++; if (bus.haddr2 !== ea) begin n_fail++; $display("FAIL sw_haddr2: got %h expected %h", bus.haddr2, ea); end
        n_chk++; if (bus.hwdata1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_hwdata1: got %h expected deadbeef", bus.hwdata1); end
        n_chk++; if (bus.hresp !== 2'b00) begin n_fail++; $display("FAIL sw_hresp: got %b expected 00", bus.hresp); end
    endtask

    task automatic test_back_to_back();
        drive(2'b10, 1'b1, 32'h8400_0000, 32'h0, 1'b1, 3'b010);
        aq.push_back(32'h8400_0000);
        #1;
        n_chk++; if (bus.tempselx !== 3'b010) begin n_fail++; $display("FAIL b2b_sel1: got %b expected 010", bus.tempselx); end
        tick();
        drive(2'b11, 1'b1, 32'h8800_0004, 32'hA5A5_0001, 1'b1, 3'b010);
        dq.push_back(32'hA5A5_0001);
        #1;
        n_chk++; if (bus.tempselx !== 3'b100) begin n_fail++; $display("FAIL b2b_sel2: got %b expected 100", bus.tempselx); end
        n_chk++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", bus.valid); end
        tick();
        ea = aq.pop_front();
        n_chk++; if (bus.haddr2 !== ea) begin n_fail++; $display("FAIL b2b_haddr2: got %h expected %h", bus.haddr2, ea); end
        n_chk++; if (bus.hwdata1 !== 32'hA5A5_0001) begin n_fail++; $display("FAIL b2b_hwdata1a: got %h expected a5a50001", bus.hwdata1); end
        drive(2'b00, 1'b0, 32'h0, 32'hA5A5_0002, 1'b1, 3'b010);
        dq.push_back(32'hA5A5_0002);
        tick();
        n_chk++; if (bus.hwdata1 !== 32'hA5A5_0002) begin n_fail++; $display("FAIL b2b_hwdata1b: got %h expected a5a50002", bus.hwdata1); end
        ea = dq.pop_front();
        n_chk++; if (bus.hwdata2 !== ea) begin n_fail++; $display("FAIL b2b_hwdata2a: got %h expected %h", bus.hwdata2, ea); end
        drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 3'b010);
        tick();
        ea = dq.pop_front();
        n_chk++; if (bus.hwdata2 !== ea) begin n_fail++; $display("FAIL b2b_hwdata2b: got %h expected %h", bus.hwdata2, ea); end
    endtask

    task automatic test_stall();
        drive(2'b10, 1'b1, 32'h8000_0100, 32'h1111_1111, 1'b1, 3'b010);
        tick();
        drive(2'b10, 1'b0, 32'h8400_0200, 32'h2222_2222, 1'b1, 3'b010);
        tick();
        drive(2'b10, 1'b1, 32'h8800_0300, 32'h3333_3333, 1'b0, 3'b010);
        #1;
        n_chk++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL st_valid: got %b expected 0", bus.valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (bus.haddr1 !== 32'h8400_0200) begin n_fail++; $display("FAIL st_haddr1[%0d]: got %h expected 84000200", i, bus.haddr1); end
            n_chk++; if (bus.haddr2 !== 32'h8000_0100) begin n_fail++; $display("FAIL st_haddr2[%0d]: got %h expected 80000100", i, bus.haddr2); end
            n_chk++; if (bus.hwdata1 !== 32'h2222_2222) begin n_fail++; $display("FAIL st_hwdata1[%0d]: got %h expected 22222222", i, bus.hwdata1); end
            n_chk++; if (bus.hwdata2 !== 32'h1111_1111) begin n_fail++; $display("FAIL st_hwdata2[%0d]: got %h expected 11111111", i, bus.hwdata2); end
            n_chk++; if (bus.hwritereg !== 1'b0) begin n_fail++; $display("FAIL st_hwritereg[%0d]: got %b expected 0", i, bus.hwritereg); end
        end
        bus.hreadyin = 1'b1;
        #1;
        n_chk++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL st_resume_valid: got %b expected 1", bus.valid); end
        tick();
        n_chk++; if (bus.haddr1 !== 32'h8800_0300) begin n_fail++; $display("FAIL st_resume_haddr1: got %h expected 88000300", bus.haddr1); end
        n_chk++; if (bus.haddr2 !== 32'h8400_0200) begin n_fail++; $display("FAIL st_resume_haddr2: got %h expected 84000200", bus.haddr2); end
        n_chk++; if (bus.hwritereg !== 1'b1) begin n_fail++; $display("FAIL st_resume_hwritereg: got %b expected 1", bus.hwritereg); end
        bus.prdata = 32'hCAFE_F00D;
        #1;
        n_chk++; if (bus.hrdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL st_hrdata: got %h expected cafef00d", bus.hrdata); end
        drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 3'b010);
        tick();
    endtask

    task automatic test_unmapped();
        drive(2'b10, 1'b0, 32'h0000_1000, 32'h0, 1'b1, 3'b010);
        rq.push_back(2'b01); hq.push_back(1'b0);
        rq.push_back(2'b01); hq.push_back(1'b1);
        rq.push_back(2'b00); hq.push_back(1'b1);
        exp_err++;
        #1;
        n_chk++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL um_valid: got %b expected 0", bus.valid); end
        n_chk++; if (bus.tempselx !== 3'b000) begin n_fail++; $display("FAIL um_sel: got %b expected 000", bus.tempselx); end
        for (int i = 0; i < 3; i++) begin
            tick();
            er = rq.pop_front(); eh = hq.pop_front();
            n_chk++; if (bus.hresp !== er) begin n_fail++; $display("FAIL um_hresp[%0d]: got %b expected %b", i, bus.hresp, er); end
            n_chk++; if (bus.err_hreadyout !== eh) begin n_fail++; $display("FAIL um_hready[%0d]: got %b expected %b", i, bus.err_hreadyout, eh); end
            if (i == 0) begin
                drive(2'b10, 1'b0, 32'h8000_0000, 32'h0, 1'b1, 3'b010);
                #1;
                n_chk++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL um_valid_in_err: got %b expected 0", bus.valid); end
            end else if (i == 1) begin
                drive(2'b10, 1'b0, 32'h0000_2000, 32'h0, 1'b1, 3'b010);
            end else begin
                drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 3'b010);
            end
        end
        n_chk++; if (bus.err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL um_count: got %h expected %h", bus.err_count, 8'(exp_err)); end
        tick();
        n_chk++; if (bus.hresp !== 2'b00) begin n_fail++; $display("FAIL um_err2_ignored: got %b expected 00", bus.hresp); end
        n_chk++; if (bus.err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL um_count_hold: got %h expected %h", bus.err_count, 8'(exp_err)); end
        drive(2'b01, 1'b0, 32'h0000_3000, 32'h0, 1'b1, 3'b010);
        tick();
        n_chk++; if (bus.hresp !== 2'b00) begin n_fail++; $display("FAIL um_busy_okay: got %b expected 00", bus.hresp); end
    endtask

    task automatic test_align();
        drive(2'b10, 1'b0, 32'h8000_0002, 32'h0, 1'b1, 3'b010);
`ifdef AHB_ALIGN_CHECK_EN
        rq.push_back(2'b01); hq.push_back(1'b0);
        rq.push_back(2'b01); hq.push_back(1'b1);
        exp_err++;
        ea = 32'h0;
`else
        rq.push_back(2'b00); hq.push_back(1'b1);
        rq.push_back(2'b00); hq.push_back(1'b1);
        ea = 32'h1;
`endif
        #1;
        n_chk++; if (bus.valid !== ea[0]) begin n_fail++; $display("FAIL al_valid: got %b expected %b", bus.valid, ea[0]); end
        n_chk++; if (bus.tempselx !== 3'b001) begin n_fail++; $display("FAIL al_sel: got %b expected 001", bus.tempselx); end
        for (int i = 0; i < 2; i++) begin
            tick();
            drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 3'b010);
            er = rq.pop_front(); eh = hq.pop_front();
            n_chk++; if (bus.hresp !== er) begin n_fail++; $display("FAIL al_hresp[%0d]: got %b expected %b", i, bus.hresp, er); end
            n_chk++; if (bus.err_hreadyout !== eh) begin n_fail++; $display("FAIL al_hready[%0d]: got %b expected %b", i, bus.err_hreadyout, eh); end
        end
        tick();
        n_chk++; if (bus.hresp !== 2'b00) begin n_fail++; $display("FAIL al_hresp_end: got %b expected 00", bus.hresp); end
        n_chk++; if (bus.err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL al_count: got %h expected %h", bus.err_count, 8'(exp_err)); end
    endtask

    task automatic test_saturation();
        drive(2'b10, 1'b0, 32'h0000_1000, 32'h0, 1'b1, 3'b010);
        for (int i = 0; i < 256; i++) begin
            tick(); tick(); tick();
            exp_err = exp_err == 255 ? 255 : exp_err + 1;
            n_chk++; if (bus.err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL sat_count[%0d]: got %h expected %h", i, bus.err_count, 8'(exp_err)); end
        end
        n_chk++; if (bus.err_count !== 8'hFF) begin n_fail++; $display("FAIL sat_final: got %h expected ff", bus.err_count); end
        drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 3'b010);
        tick();
    endtask

    task automatic test_reset_mid_error();
        drive(2'b10, 1'b0, 32'h0000_1000, 32'h0, 1'b1, 3'b010);
        tick();
        hreset = 1'b1;
        tick();
        n_chk++; if (bus.hresp !== 2'b00) begin n_fail++; $display("FAIL rme_hresp: got %b expected 00", bus.hresp); end
        n_chk++; if (bus.err_hreadyout !== 1'b1) begin n_fail++; $display("FAIL rme_hready: got %b expected 1", bus.err_hreadyout); end
        n_chk++; if (bus.err_count !== 8'h00) begin n_fail++; $display("FAIL rme_count: got %h expected 00", bus.err_count); end
        hreset = 1'b0;
        drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 3'b010);
        tick();
    endtask

    initial begin
        hreset = 1'b1;
        bus.prdata = 32'h0;
        drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 3'b010);
        test_reset();
        test_single_write();
        test_back_to_back();
        test_stall();
        test_unmapped();
        test_align();
        test_saturation();
        test_reset_mid_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_slave_interface.md
Name: ahb_slave_interface

Overview:
- AHB-side front end of the AHB-to-APB bridge. Sits directly upstream of apb_controller.
- Qualifies AHB transfers into `valid` and decodes the slave select into `tempselx`.
- Pipelines address, data and write flag into the two-deep `haddr1/haddr2/hwdata1/hwdata2/hwritereg` set that the APB FSM consumes.
- Generates the two-cycle AHB ERROR response for unmapped accesses and passes read data back to the AHB.

Parameters:
- SLV0_BASE, 32'h8000_0000, base address of APB slave 0
- SLV1_BASE, 32'h8400_0000, base address of APB slave 1
- SLV2_BASE, 32'h8800_0000, base address of APB slave 2
- REGION_SIZE, 32'h0400_0000, byte size of each slave region

Ports:
- hclk  in  1  bridge clock, rising-edge
- hreset  in  1  synchronous, active-high reset
- hwrite  in  1  AHB write flag (address phase)
- hreadyin  in  1  AHB bus ready; pipeline advances only when high
- htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hsize  in  3  AHB transfer size
- haddr  in  32  AHB address (address phase)
- hwdata  in  32  AHB write data (data phase)
- prdata  in  32  APB read data from the selected slave
- valid  out  1  qualified transfer to a mapped slave, combinational
- tempselx  out  3  one-hot slave select decoded from haddr, combinational
- hwritereg  out  1  hwrite registered one stage
- haddr1  out  32  haddr delayed 1 stage
- haddr2  out  32  haddr delayed 2 stages
- hwdata1  out  32  hwdata delayed 1 stage
- hwdata2  out  32  hwdata delayed 2 stages
- hrdata  out  32  read data to AHB; equals prdata, combinational
- hresp  out  2  AHB response: 00 OKAY, 01 ERROR, registered
- err_hreadyout  out  1  low in the first ERROR cycle, else high, registered
- err_count  out  8  saturating count of ERROR responses issued

Behaviour:
- **Decode (combinational):**
  - tempselx = 001 when SLV0_BASE <= haddr < SLV0_BASE+REGION_SIZE.
  - tempselx = 010 for SLV1, 100 for SLV2.
  - tempselx = 000 otherwise (unmapped).
  - "mapped" = tempselx != 000.
- **Active transfer:** active = hreadyin & htrans[1], i.e. NONSEQ or SEQ. IDLE and BUSY are never active and always get OKAY.
- **valid:** valid = active & mapped & (err_state == ERR_IDLE). Forced 0 while an error response is in progress.
- **Pipeline:**
  - On each rising hclk with hreadyin=1: haddr1<=haddr, haddr2<=haddr1, hwdata1<=hwdata, hwdata2<=hwdata1, hwritereg<=hwrite.
  - With hreadyin=0, all pipeline registers hold.
  - Registers load regardless of htrans.
- **Error FSM (states ERR_IDLE, ERR_1, ERR_2):**
  - ERR_IDLE -> ERR_1 when active & !mapped. Otherwise stay.
  - ERR_1 -> ERR_2 unconditionally.
  - ERR_2 -> ERR_IDLE unconditionally. A new unmapped active transfer seen in ERR_2 is ignored; the AHB master aborts after ERROR.
  - Registered outputs: the cycle after entering ERR_1 has hresp=01, err_hreadyout=0. The cycle after entering ERR_2 has hresp=01, err_hreadyout=1. Otherwise hresp=00, err_hreadyout=1.
  - An unmapped access therefore gives exactly a 2-cycle ERROR response beginning 1 cycle after the address phase.
- **err_count:** increments by 1 on each ERR_IDLE->ERR_1 transition. Saturates at 8'hFF and does not wrap.
- **Reset (hreset=1 at a rising edge):**
  - haddr1/haddr2/hwdata1/hwdata2 = 0, hwritereg = 0.
  - hresp = 00, err_hreadyout = 1, err_count = 0, FSM = ERR_IDLE.
  - Reset mid-error aborts the ERROR response immediately.
  - Reset wins over every simultaneous event.
- **Latency:** haddr1 is valid 1 cycle after the address phase, haddr2 after 2 cycles (both with hreadyin high).

Optional Feature:
- Macro: AHB_ALIGN_CHECK_EN.
- **Defined:** a transfer is also treated as unmapped (valid=0, ERROR response, err_count increments) when any of these hold:
  - hsize=001 and haddr[0]=1
  - hsize=010 and haddr[1:0]!=00
  - hsize>=011
- **Undefined:** hsize is ignored entirely and only address decode determines mapping.

Test Plan:
- Reset: hold hreset 2 cycles with random inputs -> all pipeline outputs 0, hresp=00, err_hreadyout=1, err_count=0.
- Single write: htrans=10, hwrite=1, haddr=32'h8000_0010, hreadyin=1 -> same cycle valid=1, tempselx=001. Next edge haddr1=32'h8000_0010, hwritereg=1. Following edge haddr2=32'h8000_0010.
- Back-to-back writes to 32'h8400_0000 then 32'h8800_0004, with hwdata 32'hA5A5_0001 then 32'hA5A5_0002 one cycle later -> tempselx=010 then 100; hwdata1/hwdata2 shift the two values in order.
- Stall: assert hreadyin=0 for 3 cycles mid-sequence -> haddr1/haddr2/hwdata1/hwdata2/hwritereg hold, valid=0.
- Unmapped: htrans=10, haddr=32'h0000_1000 -> valid=0, tempselx=000. Next cycle hresp=01, err_hreadyout=0. Then hresp=01, err_hreadyout=1. Then hresp=00. err_count=1. 256 such accesses -> err_count=FF.
- With AHB_ALIGN_CHECK_EN: hsize=010, haddr=32'h8000_0002, htrans=10 -> valid=0 and a 2-cycle ERROR response. Without the macro -> valid=1, hresp stays 00.
